// File: rtl/arb_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter.
// Optional build macro: ARB_TIMEOUT_EN (adds a hold-time limit per owner).
package arb_pkg;

    localparam int unsigned N_REQ        = 4;
    localparam int unsigned PTR_W        = 2;
    localparam int unsigned DEF_MAX_HOLD = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index of the set bit in a one-hot vector; zero when the vector is empty.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first set bit of (req & mask),
// searching from ptr upward modulo 4. Output is one-hot or zero.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    input  logic [N_REQ-1:0] mask,
    output logic [N_REQ-1:0] pick
);

    logic [N_REQ-1:0] cand;
    assign cand = req & mask;

    // Walk the rotation order and keep only the first candidate found.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + PTR_W'(k);
            if (!found && cand[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter with a registered, held one-hot grant.
// Optional build macro: ARB_TIMEOUT_EN -- when defined, an owner is forced to
// release after DEF_MAX_HOLD consecutive grant cycles.
module rr_arbiter_4
    import arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic             busy
);

    arb_state_t       state, state_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] pick_ptr;
    logic [N_REQ-1:0] pick_mask;
    logic [N_REQ-1:0] pick;
    logic             release_ev;
    logic             timeout_hit;

    assign owner = onehot_to_idx(grant);

    // In GRANT the search starts just past the owner and excludes it, which is
    // exactly the pointer the release will install.
    assign pick_ptr  = (state == GRANT) ? owner + PTR_W'(1) : ptr;
    assign pick_mask = (state == GRANT) ? ~grant : '1;

    rr_pick u_pick (
        .req  (req),
        .ptr  (pick_ptr),
        .mask (pick_mask),
        .pick (pick)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned MAX_HOLD = DEF_MAX_HOLD;
    localparam int unsigned HOLD_W   = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Fires on the last permitted cycle so the owner holds exactly MAX_HOLD cycles.
    assign timeout_hit = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    // Hold counter: cleared on each new grant, counts cycles spent holding it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (grant_nxt != grant) begin
            hold_cnt <= '0;
        end else if (state == GRANT) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // done has precedence over any req change; either way there is one release.
    assign release_ev = done || !(|(req & grant)) || timeout_hit;

    // Next-state, next-pointer and next-grant selection.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    grant_nxt = pick;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (release_ev) begin
                    ptr_nxt   = owner + PTR_W'(1);
                    grant_nxt = pick;
                    state_nxt = (|pick) ? GRANT : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // State, pointer and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            state <= state_nxt;
            ptr   <= ptr_nxt;
            grant <= grant_nxt;
        end
    end

    assign grant_valid = |grant;
    assign busy        = (state == GRANT);

endmodule
